rom_loader: RTL and testbench

Program loader that sits directly upstream of the instruction ROM's write port. Consumes a framed byte stream from the debug/UART receiver, assembles little-endian 32-bit words and issues one ROM write per word at consecutive word-aligned byte addresses. Holds the CPU in reset while loading and reports completion or error.

---
 rtl/rom_loader.sv | 186 ++++++++++++++++++
 tb/tb_rom_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// ============================================================================
//  Module   : rom_loader
//  Purpose  : Framed byte-stream loader for the instruction ROM. Assembles
//             little-endian words, writes them at consecutive word addresses,
//             holds the CPU in reset while loading.
//  Options  : ROM_LOADER_CSUM_EN - adds a trailing 8-bit wrapping checksum byte.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wen,
    output logic [31:0] w_addr,
    output logic [31:0] w_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int                c_WIDX_W   = ($clog2(MAX_WORDS + 1) > 13) ? $clog2(MAX_WORDS + 1) : 13;
    localparam logic [31:0]       c_MAX_N    = 32'(MAX_WORDS);
    localparam logic [c_WIDX_W-1:0] c_WIDX_ONE = c_WIDX_W'(1);
    // Low address bits are forced to zero so a misaligned BASE_ADDR cannot leak out.
    localparam logic [31:0]       c_BASE     = {BASE_ADDR[31:2], 2'b00};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
`ifdef ROM_LOADER_CSUM_EN
        S_CSUM = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_bcnt;
    logic [31:0]           r_nwords;
    logic [c_WIDX_W-1:0]   r_widx;
    logic [23:0]           r_asm;
    logic [31:0]           r_addr_nxt;
    logic [31:0]           w_nfull;
    logic                  w_all_words;
    logic                  w_pay_acc;
    logic                  w_start_acc;
`ifdef ROM_LOADER_CSUM_EN
    logic [7:0]            r_sum;
    logic                  w_csum_ok;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_nfull     = {rx_data, r_nwords[31:8]};
        w_all_words = (32'(r_widx) == r_nwords);
        w_pay_acc   = (r_state == S_DATA) && rx_valid && !w_all_words;
        w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_ERR));
`ifdef ROM_LOADER_CSUM_EN
        w_csum_ok   = (rx_data == r_sum);
`endif
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (rx_valid && (r_bcnt == 2'd3)) begin
                    if (w_nfull > c_MAX_N) begin
                        w_state_nxt = S_ERR;
                    end else if (w_nfull == 32'd0) begin
`ifdef ROM_LOADER_CSUM_EN
                        w_state_nxt = S_CSUM;
`else
                        w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // The last word was written in this cycle's wen; a checksum byte
                // may already be arriving back-to-back, so it is judged here too.
                if (w_all_words) begin
`ifdef ROM_LOADER_CSUM_EN
                    if (rx_valid) begin
                        w_state_nxt = w_csum_ok ? S_DONE : S_ERR;
                    end else begin
                        w_state_nxt = S_CSUM;
                    end
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef ROM_LOADER_CSUM_EN
            S_CSUM: begin
                if (rx_valid) w_state_nxt = w_csum_ok ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (start) w_state_nxt = S_HDR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wen        <= 1'b0;
            w_addr     <= 32'd0;
            w_data     <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            r_bcnt     <= 2'd0;
            r_nwords   <= 32'd0;
            r_widx     <= '0;
            r_asm      <= 24'd0;
            r_addr_nxt <= c_BASE;
`ifdef ROM_LOADER_CSUM_EN
            r_sum      <= 8'd0;
`endif
        end else begin
            wen      <= 1'b0;
            done     <= (w_state_nxt == S_DONE);
            err      <= (w_state_nxt == S_ERR);
            cpu_hold <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);

            if (w_start_acc) begin
                r_bcnt     <= 2'd0;
                r_nwords   <= 32'd0;
                r_widx     <= '0;
                r_asm      <= 24'd0;
                r_addr_nxt <= c_BASE;
`ifdef ROM_LOADER_CSUM_EN
                r_sum      <= 8'd0;
`endif
            end

            if ((r_state == S_HDR) && rx_valid) begin
                r_nwords <= w_nfull;
                r_bcnt   <= r_bcnt + 2'd1;
            end

            if (w_pay_acc) begin
                r_bcnt <= r_bcnt + 2'd1;
                r_asm  <= {rx_data, r_asm[23:8]};
`ifdef ROM_LOADER_CSUM_EN
                r_sum  <= r_sum + rx_data;
`endif
                if (r_bcnt == 2'd3) begin
                    wen        <= 1'b1;
                    w_data     <= {rx_data, r_asm};
                    w_addr     <= r_addr_nxt;
                    r_addr_nxt <= r_addr_nxt + 32'd4;
                    r_widx     <= r_widx + c_WIDX_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ============================================================================
//  Module   : tb_rom_loader
//  Purpose  : Directed self-checking bench for rom_loader (two instances,
//             BASE_ADDR 0 and 0x100, driven by the same byte stream).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_loader;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wen, wen_b;
    logic [31:0] w_addr, w_addr_b;
    logic [31:0] w_data, w_data_b;
    logic        cpu_hold, cpu_hold_b;
    logic        done, done_b;
    logic        err, err_b;

    int          n_chk;
    int          n_err;
    int          wen_cnt;
    int          done_cnt;
    int          base_wen;
    int          base_done;
    logic [7:0]  tb_sum;
    logic [31:0] qa[$];
    logic [31:0] qd[$];

    rom_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4096)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .wen(wen), .w_addr(w_addr), .w_data(w_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    rom_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4096)) dut_b (
        .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .wen(wen_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen) wen_cnt++;
        if (done) done_cnt++;
        if (wen_b) begin
            qa.push_back(w_addr_b);
            qd.push_back(w_data_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
        tb_sum    = 8'd0;
        base_wen  = wen_cnt;
        base_done = done_cnt;
        qa.delete();
        qd.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) step();
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] n, input int gmax);
        for (int i = 0; i < 4; i++) begin
            send_byte(n[8*i +: 8], $urandom_range(0, gmax));
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int i = 0; i < 4; i++) begin
            tb_sum = tb_sum + w[8*i +: 8];
            send_byte(w[8*i +: 8], $urandom_range(0, gmax));
        end
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_wen"},    32'(wen),  32'd1);
        check({tag, "_addr"},   w_addr,    addr);
        check({tag, "_data"},   w_data,    data);
        check({tag, "_addr_b"}, w_addr_b,  addr + 32'h100);
    endtask

    task automatic finish_ok(input string tag, input int gap);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(tb_sum, gap);
`else
        rx_valid = 1'b0;
        step();
`endif
        check({tag, "_done"},   32'(done),     32'd1);
        check({tag, "_done_b"}, 32'(done_b),   32'd1);
        check({tag, "_hold"},   32'(cpu_hold), 32'd0);
        step();
        check({tag, "_pulse"},  32'(done),     32'd0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; wen_cnt = 0; done_cnt = 0;
        base_wen = 0; base_done = 0; tb_sum = 8'd0;
        rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) step();
        check("rst_wen",  32'(wen),      32'd0);
        check("rst_addr", w_addr,        32'd0);
        check("rst_data", w_data,        32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_err",  32'(err),      32'd0);
        rstn = 1'b1;
        step();

        // Back-to-back two-word frame
        pulse_start();
        check("t1_hold", 32'(cpu_hold), 32'd1);
        send_hdr(32'd2, 0);
        check("t1_hdr_wen", 32'(wen), 32'd0);
        send_word(32'h0000_0013, 0);
        expect_write("t1_w0", 32'h0, 32'h0000_0013);
        check("t1_hold_mid", 32'(cpu_hold), 32'd1);
        send_word(32'h0000_006F, 0);
        expect_write("t1_w1", 32'h4, 32'h0000_006F);
        check("t1_hold_last", 32'(cpu_hold), 32'd1);
        finish_ok("t1", 0);
        check("t1_wcnt", 32'(wen_cnt - base_wen), 32'd2);

        // Same frame with random gaps; checked on the BASE_ADDR=0x100 instance
        pulse_start();
        send_hdr(32'd2, 5);
        send_word(32'h0000_0013, 5);
        send_word(32'h0000_006F, 5);
        finish_ok("t2", $urandom_range(0, 5));
        check("t2_nwr",   32'(qa.size()), 32'd2);
        check("t2_a0", (qa.size() > 0) ? qa[0] : 32'hxxxx_xxxx, 32'h100);
        check("t2_d0", (qd.size() > 0) ? qd[0] : 32'hxxxx_xxxx, 32'h13);
        check("t2_a1", (qa.size() > 1) ? qa[1] : 32'hxxxx_xxxx, 32'h104);
        check("t2_d1", (qd.size() > 1) ? qd[1] : 32'hxxxx_xxxx, 32'h6F);

        // Over-size header (N=4097), then recovery
        pulse_start();
        send_hdr(32'h0000_1001, 0);
        check("t3_err",  32'(err),      32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        send_word(32'h1122_3344, 0);
        check("t3_err_hold", 32'(err), 32'd1);
        check("t3_no_wen", 32'(wen_cnt - base_wen), 32'd0);
        pulse_start();
        check("t3_err_clr",  32'(err),      32'd0);
        check("t3_hold_rec", 32'(cpu_hold), 32'd1);
        send_hdr(32'd1, 0);
        send_word(32'hDEAD_BEEF, 1);
        expect_write("t3_w0", 32'h0, 32'hDEAD_BEEF);
        finish_ok("t3", 0);

        // Payload 01 02 03 04 (checksum 0x0A good, 0x0B bad when enabled)
        pulse_start();
        send_hdr(32'd1, 0);
        send_word(32'h0403_0201, 0);
        expect_write("t4_w0", 32'h0, 32'h0403_0201);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(8'h0A, 2);
        check("t4_done_good", 32'(done), 32'd1);
        step();
        pulse_start();
        send_hdr(32'd1, 0);
        send_word(32'h0403_0201, 0);
        send_byte(8'h0B, 0);
        check("t4_err_bad",  32'(err),      32'd1);
        check("t4_hold_bad", 32'(cpu_hold), 32'd1);
        repeat (3) step();
        check("t4_no_done", 32'(done_cnt - base_done), 32'd0);
        pulse_start();
        check("t4_err_clr", 32'(err), 32'd0);
        send_hdr(32'd0, 0);
        send_byte(8'h00, 0);
        check("t4_recover", 32'(done), 32'd1);
        step();
`else
        finish_ok("t4", 0);
`endif

        // Reset after two payload bytes
        pulse_start();
        send_hdr(32'd1, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rstn = 1'b0;
        step();
        check("t5_wen",  32'(wen),      32'd0);
        check("t5_addr", w_addr,        32'd0);
        check("t5_data", w_data,        32'd0);
        check("t5_hold", 32'(cpu_hold), 32'd0);
        check("t5_err",  32'(err),      32'd0);
        rstn = 1'b1;
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        step();
        check("t5_no_wen", 32'(wen_cnt - base_wen), 32'd0);
        pulse_start();
        send_hdr(32'd2, 0);
        send_word(32'hCAFE_F00D, 0);
        expect_write("t5_w0", 32'h0, 32'hCAFE_F00D);
        send_word(32'h1234_5678, 0);
        expect_write("t5_w1", 32'h4, 32'h1234_5678);
        finish_ok("t5", 0);

        // Empty frame
        pulse_start();
        send_hdr(32'd0, 0);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(8'h00, 0);
`endif
        check("t6_done", 32'(done),     32'd1);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_no_wen", 32'(wen_cnt - base_wen), 32'd0);
        step();

        // start held high during DATA must not restart the frame
        pulse_start();
        send_hdr(32'd2, 0);
        start = 1'b1;
        send_word(32'hA5A5_0001, 0);
        start = 1'b0;
        expect_write("t7_w0", 32'h0, 32'hA5A5_0001);
        send_word(32'h5A5A_0002, 0);
        expect_write("t7_w1", 32'h4, 32'h5A5A_0002);
        finish_ok("t7", 0);
        check("t7_wcnt", 32'(wen_cnt - base_wen), 32'd2);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
